// File: rtl/timer_pkg.sv
// timer_pkg: state encoding and timing constants shared by the game timers
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One second of the 100 MHz system clock, also used by the elapsed-time up-counter
    localparam int DEFAULT_TICKS_PER_SEC = 100000000;

endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides clock_100Mhz down to a one-cycle strobe once per second
//   clock_100Mhz  system clock
//   reset         asynchronous active-low reset
//   enable        advance the cycle counter this cycle; when low the counter holds
//   clear         restart the second from zero (takes priority over enable)
//   wrap          high in the cycle the counter rolls from TICKS_PER_SEC-1 to 0
module sec_prescaler
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TOP = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] cycles;
    logic          at_top;

    assign at_top = cycles == TOP;
    assign wrap   = enable && !clear && at_top;

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset)
            cycles <= '0;
        else if (clear)
            cycles <= '0;
        else if (enable)
            cycles <= at_top ? '0 : cycles + 1'b1;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds countdown with pause/resume and expiry for the crane game
//   clock_100Mhz   system clock
//   reset          asynchronous active-low reset
//   load           strobe: take load_value as the new count and return to IDLE
//   load_value     seconds to count down from
//   start          strobe: begin or resume counting
//   pause          strobe: freeze counting, keeping the partial second
//   count          seconds remaining
//   running        counting is active
//   expired        level, round over
//   expired_pulse  one-cycle strobe on reaching DONE
//   tick           one-cycle strobe on each decrement
//   warning        running with few seconds left
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC  = DEFAULT_TICKS_PER_SEC,
    parameter int WIDTH          = 16,
    parameter int WARN_THRESHOLD = 10
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             expired_pulse,
    output logic             tick,
    output logic             warning
);

    localparam logic [WIDTH-1:0] WARN = WIDTH'(WARN_THRESHOLD);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             tick_n, expired_pulse_n;
    logic             pre_en, pre_clear, wrap;

    // The prescaler only advances in RUN when nothing higher-priority is pending,
    // so a pause coinciding with the last cycle of a second leaves it at the top.
    assign pre_en    = state == ST_RUN && !pause && !load;
    assign pre_clear = load || (state == ST_IDLE && start);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .enable      (pre_en),
        .clear       (pre_clear),
        .wrap        (wrap)
    );

    always_comb begin
        state_n         = state;
        count_n         = count;
        tick_n          = 1'b0;
        expired_pulse_n = 1'b0;
        if (load) begin
            state_n = ST_IDLE;
            count_n = load_value;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n         = count != '0 ? ST_RUN : ST_DONE;
                        expired_pulse_n = count == '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (wrap && count != '0) begin
                        count_n         = count - 1'b1;
                        tick_n          = 1'b1;
                        state_n         = count == WIDTH'(1) ? ST_DONE : ST_RUN;
                        expired_pulse_n = count == WIDTH'(1);
                    end
                end
                ST_PAUSED: state_n = start ? ST_RUN : ST_PAUSED;
                default:   count_n = '0;
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            tick          <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            tick          <= tick_n;
            expired_pulse <= expired_pulse_n;
        end
    end

    assign running = state == ST_RUN;
    assign expired = state == ST_DONE;
    assign warning = running && count != '0 && count <= WARN;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer (1 s = 4 cycles, warn at 2)
module tb_countdown_timer;

    logic        clock_100Mhz = 1'b0;
    logic        reset        = 1'b0;
    logic        load         = 1'b0;
    logic [15:0] load_value   = '0;
    logic        start        = 1'b0;
    logic        pause        = 1'b0;
    logic [15:0] count;
    logic        running, expired, expired_pulse, tick, warning;

    int checks = 0;
    int errors = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    countdown_timer #(
        .TICKS_PER_SEC (4),
        .WIDTH         (16),
        .WARN_THRESHOLD(2)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .load         (load),
        .load_value   (load_value),
        .start        (start),
        .pause        (pause),
        .count        (count),
        .running      (running),
        .expired      (expired),
        .expired_pulse(expired_pulse),
        .tick         (tick),
        .warning      (warning)
    );

    task automatic step();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_value = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({running, expired, expired_pulse, tick, warning} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {running, expired, expired_pulse, tick, warning}); end
        reset = 1'b1;
        step();
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL reset_release count=%0d running=%b exp=0/0", count, running); end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        do_load(16'd3);
        checks++; if (count !== 16'd3 || running !== 1'b0) begin errors++; $display("FAIL basic_load count=%0d running=%b exp=3/0", count, running); end
        do_start();
        checks++; if (running !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL basic_start running=%b tick=%b exp=1/0", running, tick); end
        for (int i = 1; i <= 12; i++) begin
            step();
            e = 16'(3 - i / 4);
            checks++; if (tick !== (i % 4 == 0)) begin errors++; $display("FAIL basic_tick cyc=%0d got=%b exp=%b", i, tick, i % 4 == 0); end
            checks++; if (count !== e) begin errors++; $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", i, count, e); end
            checks++; if (expired_pulse !== (i == 12)) begin errors++; $display("FAIL basic_xpulse cyc=%0d got=%b exp=%b", i, expired_pulse, i == 12); end
        end
        checks++; if (expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL basic_done expired=%b running=%b exp=1/0", expired, running); end
        do_start();
        step();
        checks++; if ({expired, expired_pulse, tick, count} !== {3'b100, 16'd0}) begin errors++; $display("FAIL basic_hold expired=%b xp=%b tick=%b count=%0d exp=1/0/0/0", expired, expired_pulse, tick, count); end
    endtask

    task automatic test_pause();
        do_load(16'd3);
        do_start();
        step();
        step();
        do_pause();
        checks++; if (running !== 1'b0 || count !== 16'd3) begin errors++; $display("FAIL pause_enter running=%b count=%0d exp=0/3", running, count); end
        for (int i = 0; i < 10; i++) begin
            if (i == 5) pause = 1'b1;
            step();
            pause = 1'b0;
            checks++; if (count !== 16'd3 || tick !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL pause_hold cyc=%0d count=%0d tick=%b running=%b exp=3/0/0", i, count, tick, running); end
        end
        do_start();
        checks++; if (running !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL pause_resume running=%b tick=%b exp=1/0", running, tick); end
        step();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL pause_early_tick got=%b exp=0", tick); end
        step();
        checks++; if (tick !== 1'b1 || count !== 16'd2) begin errors++; $display("FAIL pause_first_tick tick=%b count=%0d exp=1/2", tick, count); end
    endtask

    task automatic test_zero();
        do_load(16'd0);
        do_start();
        checks++; if ({expired, expired_pulse, tick, running} !== 4'b1100 || count !== 16'd0) begin errors++; $display("FAIL zero_start flags=%b count=%0d exp=1100/0", {expired, expired_pulse, tick, running}, count); end
        step();
        checks++; if (expired_pulse !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL zero_pulse_width xp=%b expired=%b exp=0/1", expired_pulse, expired); end
    endtask

    task automatic test_pause_at_tick();
        do_load(16'd5);
        do_start();
        step();
        step();
        step();
        do_pause();
        checks++; if (tick !== 1'b0 || count !== 16'd5 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL coinc_pause tick=%b count=%0d running=%b expired=%b exp=0/5/0/0", tick, count, running, expired); end
        load = 1'b1; load_value = 16'd7; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        checks++; if (count !== 16'd7 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL load_start count=%0d running=%b expired=%b exp=7/0/0", count, running, expired); end
        step();
        checks++; if (running !== 1'b0 || count !== 16'd7) begin errors++; $display("FAIL load_idle running=%b count=%0d exp=0/7", running, count); end
    endtask

    task automatic test_warning();
        logic [15:0] e;
        logic        w;
        do_load(16'd4);
        do_start();
        checks++; if (warning !== 1'b0) begin errors++; $display("FAIL warn_start got=%b exp=0", warning); end
        for (int i = 1; i <= 16; i++) begin
            step();
            e = 16'(4 - i / 4);
            w = e != 16'd0 && e <= 16'd2;
            checks++; if (warning !== w || count !== e) begin errors++; $display("FAIL warn cyc=%0d warning=%b count=%0d exp=%b/%0d", i, warning, count, w, e); end
        end
        checks++; if (expired !== 1'b1) begin errors++; $display("FAIL warn_done expired=%b exp=1", expired); end
    endtask

    task automatic test_async_reset();
        do_load(16'd9);
        do_start();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL areset_now count=%0d running=%b exp=0/0", count, running); end
        step();
        checks++; if (expired_pulse !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL areset_held xp=%b expired=%b exp=0/0", expired_pulse, expired); end
        #2 reset = 1'b1;
        step();
        checks++; if ({running, expired, expired_pulse, tick} !== 4'b0 || count !== 16'd0) begin errors++; $display("FAIL areset_idle flags=%b count=%0d exp=0000/0", {running, expired, expired_pulse, tick}, count); end
        do_start();
        checks++; if (expired_pulse !== 1'b1 || expired !== 1'b1) begin errors++; $display("FAIL areset_start xp=%b expired=%b exp=1/1", expired_pulse, expired); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_zero();
        test_pause_at_tick();
        test_warning();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
